// File: rtl/debug_stream_arbiter.sv
// Round-robin merge of N_SRC packet sources onto one debug stream, with
// length truncation, forced inter-packet gaps and a saturating drop counter.
module debug_stream_arbiter #(
  parameter int N_SRC      = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                  ipClk,
  input  logic                  ipnReset,
  input  logic [N_SRC-1:0]      ipEnable,
  input  logic [12:0]           ipMaxLength,
  input  logic [N_SRC-1:0]      ipValid,
  input  logic [N_SRC-1:0]      ipSoP,
  input  logic [N_SRC-1:0]      ipEoP,
  input  logic [14*N_SRC-1:0]   ipData,
  output logic                  opValid,
  output logic                  opSoP,
  output logic                  opEoP,
  output logic [13:0]           opData,
  output logic [2:0]            opSource,
  output logic [15:0]           opDropCount,
  output logic                  opTruncated
);

  typedef enum logic [1:0] {Idle, Stream, Discard, Gap} state_t;

  state_t      state_reg;
  logic [1:0]  rst_sync_reg;
  logic [2:0]  last_reg;
  logic [12:0] beat_cnt_reg;
  logic [3:0]  gap_cnt_reg;

  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] grant_mask;
  logic [13:0]      src_data [N_SRC];

  logic        rr_found;
  logic [2:0]  rr_idx;
  logic        rr_eop;
  logic [13:0] rr_data;
  int          rr_best;
  int          rr_dist;
  logic        g_valid;
  logic        g_eop;
  logic [13:0] g_data;
  logic [3:0]  drop_add;
  logic [16:0] drop_sum;
  logic [15:0] drop_next;
  logic [12:0] cnt_inc;
  logic        ready;

  assign cand    = ipEnable & ipValid & ipSoP;
  assign cnt_inc = beat_cnt_reg + 13'd1;
  assign ready   = rst_sync_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign src_data[gi]   = ipData[14*gi +: 14];
      assign grant_mask[gi] = (last_reg == 3'(gi));
    end
  endgenerate

  function automatic logic [3:0] popcnt(input logic [N_SRC-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < N_SRC; k++) c = c + {3'd0, v[k]};
    return c;
  endfunction

  // Smallest rotational distance from last grant + 1 wins the arbitration.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_eop   = 1'b0;
    rr_data  = '0;
    rr_best  = N_SRC;
    rr_dist  = 0;
    g_valid  = 1'b0;
    g_eop    = 1'b0;
    g_data   = '0;
    for (int k = 0; k < N_SRC; k++) begin
      rr_dist = (k + N_SRC - 1 - int'(last_reg)) % N_SRC;
      if (cand[k] && rr_dist < rr_best) begin
        rr_best  = rr_dist;
        rr_found = 1'b1;
        rr_idx   = 3'(k);
        rr_eop   = ipEoP[k];
        rr_data  = src_data[k];
      end
      if (last_reg == 3'(k)) begin
        g_valid = ipValid[k];
        g_eop   = ipEoP[k];
        g_data  = src_data[k];
      end
    end
  end

  always_comb begin
    drop_add = '0;
    case (state_reg)
      Idle:            drop_add = (ready && rr_found) ? popcnt(cand) - 4'd1 : 4'd0;
      Stream, Discard: drop_add = popcnt(cand & ~grant_mask);
      Gap:             drop_add = popcnt(cand);
      default:         drop_add = '0;
    endcase
    drop_sum  = {1'b0, opDropCount} + {13'd0, drop_add};
    drop_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  always_ff @(posedge ipClk or negedge ipnReset) begin
    if (!ipnReset) begin
      state_reg    <= Idle;
      rst_sync_reg <= 2'b00;
      last_reg     <= 3'(N_SRC - 1);
      beat_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      opValid      <= 1'b0;
      opSoP        <= 1'b0;
      opEoP        <= 1'b0;
      opTruncated  <= 1'b0;
      opData       <= '0;
      opSource     <= '0;
      opDropCount  <= '0;
    end else begin
      rst_sync_reg <= {rst_sync_reg[0], 1'b1};
      opDropCount  <= drop_next;
      opValid      <= 1'b0;
      opSoP        <= 1'b0;
      opEoP        <= 1'b0;
      opTruncated  <= 1'b0;
      case (state_reg)
        Idle: begin
          if (ready && rr_found) begin
            last_reg     <= rr_idx;
            opValid      <= 1'b1;
            opSoP        <= 1'b1;
            opData       <= rr_data;
            opSource     <= rr_idx;
            beat_cnt_reg <= 13'd1;
            if (rr_eop) begin
              opEoP       <= 1'b1;
              gap_cnt_reg <= 4'(GAP_CYCLES);
              state_reg   <= Gap;
            end else if (ipMaxLength == 13'd1) begin
              opEoP       <= 1'b1;
              opTruncated <= 1'b1;
              state_reg   <= Discard;
            end else begin
              state_reg <= Stream;
            end
          end
        end
        Stream: begin
          opValid <= g_valid;
          if (g_valid) begin
            opData       <= g_data;
            beat_cnt_reg <= cnt_inc;
            if (g_eop) begin
              opEoP       <= 1'b1;
              gap_cnt_reg <= 4'(GAP_CYCLES);
              state_reg   <= Gap;
            end else if (ipMaxLength != 13'd0 && cnt_inc == ipMaxLength) begin
              opEoP       <= 1'b1;
              opTruncated <= 1'b1;
              state_reg   <= Discard;
            end
          end
        end
        Discard: begin
          if (g_valid && g_eop) begin
            gap_cnt_reg <= 4'(GAP_CYCLES);
            state_reg   <= Gap;
          end
        end
        Gap: begin
          if (gap_cnt_reg <= 4'd1) state_reg <= Idle;
          else gap_cnt_reg <= gap_cnt_reg - 4'd1;
        end
        default: state_reg <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_stream_arbiter.sv
// Directed bench for debug_stream_arbiter: arbitration, truncation, gaps,
// enable handling, drop counting and reset behaviour.
module tb_debug_stream_arbiter;

  logic        ipClk = 1'b0;
  logic        ipnReset;
  logic [3:0]  ipEnable;
  logic [12:0] ipMaxLength;
  logic [3:0]  ipValid;
  logic [3:0]  ipSoP;
  logic [3:0]  ipEoP;
  logic [55:0] ipData;
  logic        opValid;
  logic        opSoP;
  logic        opEoP;
  logic [13:0] opData;
  logic [2:0]  opSource;
  logic [15:0] opDropCount;
  logic        opTruncated;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_drop;

  debug_stream_arbiter #(.N_SRC(4), .GAP_CYCLES(2)) dut (
    .ipClk(ipClk), .ipnReset(ipnReset), .ipEnable(ipEnable),
    .ipMaxLength(ipMaxLength), .ipValid(ipValid), .ipSoP(ipSoP),
    .ipEoP(ipEoP), .ipData(ipData), .opValid(opValid), .opSoP(opSoP),
    .opEoP(opEoP), .opData(opData), .opSource(opSource),
    .opDropCount(opDropCount), .opTruncated(opTruncated)
  );

  always #5 ipClk = ~ipClk;

  task automatic step();
    @(posedge ipClk);
    #1;
  endtask

  task automatic idle_inputs();
    ipValid = 4'b0;
    ipSoP   = 4'b0;
    ipEoP   = 4'b0;
  endtask

  function automatic logic [13:0] dval(input int k, input int b);
    return 14'(k * 1000 + b);
  endfunction

  task automatic set_data(input int b);
    for (int k = 0; k < 4; k++) ipData[14*k +: 14] = dval(k, b);
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 ipnReset = 1'b0;
    step();
    step();
    ipnReset = 1'b1;
    step();
    step();
    step();
    exp_drop = 16'd0;
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++;
    if ({opValid, opSoP, opEoP, opTruncated, opSource, opData, opDropCount} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b s=%b e=%b t=%b src=%0d data=%0d drop=%0d, want all 0",
               opValid, opSoP, opEoP, opTruncated, opSource, opData, opDropCount);
    end
    ipnReset = 1'b1;
    set_data(0);
    ipValid = 4'b0010; ipSoP = 4'b0010; ipEoP = 4'b0010;
    step();
    n_checks++;
    if (opValid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_first_edge: opValid=%b, want 0", opValid);
    end
    idle_inputs();
    step();
    step();
    exp_drop = opDropCount;
  endtask

  task automatic test_round_robin();
    int exp_src;
    set_data(0);
    for (int p = 0; p < 5; p++) begin
      ipValid = 4'hF; ipSoP = 4'hF; ipEoP = 4'hF;
      step();
      exp_src  = p % 4;
      exp_drop = exp_drop + 16'd3;
      n_checks++;
      if ({opValid, opSoP, opEoP, opTruncated, opSource, opData} !==
          {1'b1, 1'b1, 1'b1, 1'b0, 3'(exp_src), dval(exp_src, 0)}) begin
        n_fail++;
        $display("FAIL rr_grant%0d: v=%b s=%b e=%b t=%b src=%0d data=%0d, want 1 1 1 0 src=%0d data=%0d",
                 p, opValid, opSoP, opEoP, opTruncated, opSource, opData, exp_src, dval(exp_src, 0));
      end
      n_checks++;
      if (opDropCount !== exp_drop) begin
        n_fail++;
        $display("FAIL rr_drop%0d: drop=%0d, want %0d", p, opDropCount, exp_drop);
      end
      for (int g = 0; g < 2; g++) begin
        step();
        exp_drop = exp_drop + 16'd4;
        n_checks++;
        if (opValid !== 1'b0 || opDropCount !== exp_drop) begin
          n_fail++;
          $display("FAIL rr_gap%0d_%0d: v=%b drop=%0d, want v=0 drop=%0d",
                   p, g, opValid, opDropCount, exp_drop);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_two_sop();
    do_reset();
    for (int b = 0; b < 4; b++) begin
      set_data(b);
      ipValid = 4'b0101;
      ipSoP   = (b == 0) ? 4'b0101 : 4'b0000;
      ipEoP   = (b == 3) ? 4'b0101 : 4'b0000;
      step();
      if (b == 0) exp_drop = 16'd1;
      n_checks++;
      if ({opValid, opSoP, opEoP, opTruncated, opSource, opData} !==
          {1'b1, (b == 0), (b == 3), 1'b0, 3'd0, dval(0, b)}) begin
        n_fail++;
        $display("FAIL two_sop_beat%0d: v=%b s=%b e=%b t=%b src=%0d data=%0d, want src=0 data=%0d",
                 b, opValid, opSoP, opEoP, opTruncated, opSource, opData, dval(0, b));
      end
    end
    idle_inputs();
    for (int g = 0; g < 2; g++) begin
      step();
      n_checks++;
      if (opValid !== 1'b0 || opData !== dval(0, 3) || opSource !== 3'd0) begin
        n_fail++;
        $display("FAIL two_sop_gap%0d: v=%b data=%0d src=%0d, want v=0 data=%0d src=0",
                 g, opValid, opData, opSource, dval(0, 3));
      end
    end
    n_checks++;
    if (opDropCount !== exp_drop) begin
      n_fail++;
      $display("FAIL two_sop_drop: drop=%0d, want %0d", opDropCount, exp_drop);
    end
  endtask

  task automatic test_truncate();
    ipMaxLength = 13'd8;
    for (int b = 0; b < 20; b++) begin
      set_data(b);
      ipValid = 4'b0010;
      ipSoP   = (b == 0)  ? 4'b0010 : 4'b0000;
      ipEoP   = (b == 19) ? 4'b0010 : 4'b0000;
      step();
      n_checks++;
      if (b < 8) begin
        if ({opValid, opSoP, opEoP, opTruncated, opSource, opData} !==
            {1'b1, (b == 0), (b == 7), (b == 7), 3'd1, dval(1, b)}) begin
          n_fail++;
          $display("FAIL trunc_beat%0d: v=%b s=%b e=%b t=%b src=%0d data=%0d, want data=%0d",
                   b, opValid, opSoP, opEoP, opTruncated, opSource, opData, dval(1, b));
        end
      end else begin
        if ({opValid, opEoP, opTruncated, opData} !== {1'b0, 1'b0, 1'b0, dval(1, 7)}) begin
          n_fail++;
          $display("FAIL trunc_discard%0d: v=%b e=%b t=%b data=%0d, want 0 0 0 data=%0d",
                   b, opValid, opEoP, opTruncated, opData, dval(1, 7));
        end
      end
    end
    idle_inputs();
    for (int g = 0; g < 2; g++) begin
      step();
      n_checks++;
      if (opValid !== 1'b0 || opTruncated !== 1'b0) begin
        n_fail++;
        $display("FAIL trunc_gap%0d: v=%b t=%b, want 0 0", g, opValid, opTruncated);
      end
    end
    ipMaxLength = 13'd0;
  endtask

  task automatic test_enable();
    ipEnable = 4'b0111;
    set_data(0);
    ipValid = 4'b1000; ipSoP = 4'b1000; ipEoP = 4'b1000;
    step();
    n_checks++;
    if (opValid !== 1'b0 || opDropCount !== exp_drop) begin
      n_fail++;
      $display("FAIL disabled_src: v=%b drop=%0d, want v=0 drop=%0d", opValid, opDropCount, exp_drop);
    end
    for (int b = 0; b < 4; b++) begin
      set_data(b);
      if (b == 1) ipEnable = 4'b1110;
      ipValid = (b >= 2) ? 4'b1001 : 4'b0001;
      ipSoP   = (b == 0) ? 4'b0001 : ((b == 2) ? 4'b1000 : 4'b0000);
      ipEoP   = (b == 3) ? 4'b1001 : 4'b0000;
      step();
      if (b == 2) exp_drop = exp_drop + 16'd1;
      n_checks++;
      if ({opValid, opSoP, opEoP, opSource, opData, opDropCount} !==
          {1'b1, (b == 0), (b == 3), 3'd0, dval(0, b), exp_drop}) begin
        n_fail++;
        $display("FAIL enable_beat%0d: v=%b s=%b e=%b src=%0d data=%0d drop=%0d, want data=%0d drop=%0d",
                 b, opValid, opSoP, opEoP, opSource, opData, opDropCount, dval(0, b), exp_drop);
      end
    end
    idle_inputs();
    step();
    step();
    ipEnable = 4'hF;
    set_data(5);
    ipValid = 4'b1000; ipSoP = 4'b1000; ipEoP = 4'b1000;
    step();
    n_checks++;
    if ({opValid, opSoP, opEoP, opSource, opData} !== {1'b1, 1'b1, 1'b1, 3'd3, dval(3, 5)}) begin
      n_fail++;
      $display("FAIL enable_next_pkt: v=%b s=%b e=%b src=%0d data=%0d, want 1 1 1 src=3 data=%0d",
               opValid, opSoP, opEoP, opSource, opData, dval(3, 5));
    end
    idle_inputs();
    step();
    step();
  endtask

  task automatic test_single_beat();
    set_data(7);
    ipValid = 4'b0100; ipSoP = 4'b0100; ipEoP = 4'b0100;
    step();
    n_checks++;
    if ({opValid, opSoP, opEoP, opTruncated, opSource, opData} !==
        {1'b1, 1'b1, 1'b1, 1'b0, 3'd2, dval(2, 7)}) begin
      n_fail++;
      $display("FAIL single_beat: v=%b s=%b e=%b t=%b src=%0d data=%0d, want 1 1 1 0 src=2 data=%0d",
               opValid, opSoP, opEoP, opTruncated, opSource, opData, dval(2, 7));
    end
    idle_inputs();
    set_data(9);
    step();
    n_checks++;
    if ({opValid, opSource, opData} !== {1'b0, 3'd2, dval(2, 7)}) begin
      n_fail++;
      $display("FAIL single_hold: v=%b src=%0d data=%0d, want v=0 src=2 data=%0d",
               opValid, opSource, opData, dval(2, 7));
    end
    step();
  endtask

  task automatic test_reset_mid();
    for (int b = 0; b < 3; b++) begin
      set_data(b);
      ipValid = 4'b0010;
      ipSoP   = (b == 0) ? 4'b0010 : 4'b0000;
      ipEoP   = 4'b0000;
      step();
      n_checks++;
      if ({opValid, opSource, opData} !== {1'b1, 3'd1, dval(1, b)}) begin
        n_fail++;
        $display("FAIL rstmid_beat%0d: v=%b src=%0d data=%0d, want 1 src=1 data=%0d",
                 b, opValid, opSource, opData, dval(1, b));
      end
    end
    set_data(3);
    #2 ipnReset = 1'b0;
    #1;
    n_checks++;
    if ({opValid, opSoP, opEoP, opTruncated, opSource, opData, opDropCount} !== 37'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: v=%b s=%b e=%b t=%b src=%0d data=%0d drop=%0d, want all 0",
               opValid, opSoP, opEoP, opTruncated, opSource, opData, opDropCount);
    end
    idle_inputs();
    step();
    ipnReset = 1'b1;
    step();
    step();
    step();
    set_data(4);
    ipValid = 4'hF; ipSoP = 4'hF; ipEoP = 4'hF;
    step();
    n_checks++;
    if ({opValid, opSoP, opEoP, opSource, opData, opDropCount} !==
        {1'b1, 1'b1, 1'b1, 3'd0, dval(0, 4), 16'd3}) begin
      n_fail++;
      $display("FAIL rstmid_regrant: v=%b s=%b e=%b src=%0d data=%0d drop=%0d, want src=0 data=%0d drop=3",
               opValid, opSoP, opEoP, opSource, opData, opDropCount, dval(0, 4));
    end
    idle_inputs();
    step();
    step();
  endtask

  initial begin
    ipnReset    = 1'b0;
    ipEnable    = 4'hF;
    ipMaxLength = 13'd0;
    ipData      = '0;
    exp_drop    = 16'd0;
    idle_inputs();
    test_reset();
    test_round_robin();
    test_two_sop();
    test_truncate();
    test_enable();
    test_single_beat();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/debug_stream_arbiter.md
DEBUG_STREAM_ARBITER -- requirements
Module: debug_stream_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter: N_SRC, default 4, number of packet sources (2..8).
REQ-003 Parameter: GAP_CYCLES, default 2, idle output cycles forced after each packet (1..15).
REQ-004 Port: ipClk  in  1  system clock.
REQ-005 Port: ipnReset  in  1  asynchronous active-low reset.
REQ-006 Port: ipEnable  in  N_SRC  per-source capture enable (ARM register).
REQ-007 Port: ipMaxLength  in  13  maximum packet length in beats; 0 means unlimited.
REQ-008 Port: ipValid / ipSoP / ipEoP  in  N_SRC each  per-source packet strobes.
REQ-009 Port: ipData  in  14*N_SRC  per-source samples; source k occupies bits [14k+13:14k].
REQ-010 Port: opValid / opSoP / opEoP  out  1 each  merged packet strobes to the debug streamer.
REQ-011 Port: opData  out  14  merged sample.
REQ-012 Port: opSource  out  3  index of the granted source, valid while opValid is high.
REQ-013 Port: opDropCount  out  16  saturating count of dropped packets.
REQ-014 Port: opTruncated  out  1  one-cycle pulse when a packet is cut at ipMaxLength.

Function
REQ-015 All outputs SHALL be registered, with one cycle of latency from input beat to output beat.
REQ-016 Inputs SHALL have no backpressure; beats from sources that are not granted SHALL be discarded.
REQ-017 The state machine SHALL have four states: Idle, Stream, Discard, Gap.
REQ-018 Idle: a candidate is any source k with ipEnable[k] & ipValid[k] & ipSoP[k].
REQ-019 Idle: with one or more candidates, grant SHALL go round-robin, starting at (last grant + 1) mod N_SRC.
REQ-020 On grant, the block SHALL forward that beat with opSoP=1, load the beat counter with 1, and move to Stream.
REQ-021 Each candidate not granted in the grant cycle SHALL add 1 to opDropCount.
REQ-022 Stream: only the granted source SHALL be forwarded, with opValid = ipValid[g] and opSoP forced to 0.
REQ-023 Stream: the beat counter SHALL increment on each valid beat.
REQ-024 Stream: valid & EoP SHALL forward opEoP=1 and move to Gap.
REQ-025 Stream: an SoP from another enabled source SHALL add 1 to opDropCount.
REQ-026 Stream: a second SoP from the granted source without EoP SHALL be treated as data and forwarded with opSoP forced to 0.
REQ-027 Truncation: when ipMaxLength != 0 and a valid beat brings the count to ipMaxLength without EoP, that beat SHALL go out with opEoP=1 and opTruncated=1, and the state SHALL move to Discard.
REQ-028 Discard: opValid SHALL be 0; the state SHALL stay in Discard until valid & EoP on the granted source, then move to Gap.
REQ-029 Gap: opValid SHALL be 0 for exactly GAP_CYCLES cycles, then the state SHALL return to Idle; this lets the streamer publish its write pointer.
REQ-030 Gap and Discard: enabled-source SoPs SHALL add 1 to opDropCount.
REQ-031 Simultaneous EoP and SoP on a single beat at grant SHALL produce a one-beat packet with opSoP=opEoP=1, then Gap.
REQ-032 Clearing ipEnable[g] mid-packet SHALL NOT abort the packet; enable is sampled only at grant.
REQ-033 A change to ipMaxLength mid-packet SHALL take effect on the next beat compare.
REQ-034 opDropCount SHALL saturate at 16'hFFFF; multiple drops in one cycle SHALL add their total.
REQ-035 The beat counter SHALL be 13 bits; with ipMaxLength=0 it SHALL wrap without effect.
REQ-036 opData and opSource SHALL hold their last value when opValid=0.

Reset
REQ-037 Asserting ipnReset low SHALL force, asynchronously: state Idle; opValid, opSoP, opEoP, opTruncated = 0; opData = 0; opSource = 0; opDropCount = 0; last grant = N_SRC-1, so that source 0 has first priority.
REQ-038 Reset during Stream SHALL end the packet at once, with no opEoP issued.
REQ-039 Deassertion SHALL be synchronised internally, and the block SHALL accept a grant no earlier than the second rising edge after release.

Verification
REQ-040 Scenario: after reset, sources 0 and 2 give SoP in the same cycle, 4-beat packets -> source 0 forwarded, opSource=0, opDropCount=1, then 2 idle cycles.
REQ-041 Scenario: repeated simultaneous SoPs on all 4 sources -> grants 0,1,2,3,0, each followed by GAP_CYCLES idle cycles.
REQ-042 Scenario: ipMaxLength=8, 20-beat packet on source 1 -> beat 8 out with opEoP=1 and opTruncated=1; beats 9-20 suppressed; then Gap.
REQ-043 Scenario: source 3 disabled, SoP on source 3 -> no output, opDropCount unchanged; enable set mid-packet -> next packet only.
REQ-044 Scenario: single-beat SoP+EoP on source 2 -> one output beat with opSoP=opEoP=1, opSource=2.
REQ-045 Scenario: ipnReset pulsed low at beat 3 of a packet -> outputs 0 on the same cycle; opDropCount=0; next grant goes to source 0.
